// File: rtl/id_hazard_if.sv
// Signal bundle between the decode stage datapath and its hazard controller.
interface id_hazard_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IF_ID_instr;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ext_zero;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output IF_ID_instr, id_ex_memread, id_ex_rt, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ext_zero, stall_count
    );

    modport slave (
        input  IF_ID_instr, id_ex_memread, id_ex_rt, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ext_zero, stall_count
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage pipeline controller: load-use stalls, taken-branch flushes,
// post-reset flush hold, immediate extender select and a load-use stall counter.
module id_hazard_ctrl #(
    parameter int INIT_CYCLES    = 4,
    parameter int LOAD_STALL     = 1,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    id_hazard_if.slave bus
);
    localparam int MAX_CNT = (INIT_CYCLES > LOAD_STALL) ?
        ((INIT_CYCLES > BRANCH_PENALTY) ? INIT_CYCLES : BRANCH_PENALTY) :
        ((LOAD_STALL  > BRANCH_PENALTY) ? LOAD_STALL  : BRANCH_PENALTY);
    localparam int CW = $clog2(MAX_CNT) + 1;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL, S_FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_stall_inc;
    logic             w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_bubble;

    logic [5:0] w_op;
    logic [4:0] w_rs, w_rt;
    logic       w_uses_rt, w_hazard, w_unused;

    assign w_op     = bus.IF_ID_instr[31:26];
    assign w_rs     = bus.IF_ID_instr[25:21];
    assign w_rt     = bus.IF_ID_instr[20:16];
    assign w_unused = ^bus.IF_ID_instr[15:0];

    // R-type, beq, bne and sw read rt as a source; everything else only reads rs.
    assign w_uses_rt = (w_op == 6'h00) || (w_op == 6'h04) || (w_op == 6'h05) || (w_op == 6'h2B);
    assign w_hazard  = bus.id_ex_memread && (bus.id_ex_rt != 5'd0) &&
                       ((bus.id_ex_rt == w_rs) || (w_uses_rt && (bus.id_ex_rt == w_rt)));

    assign bus.ext_zero = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stall_inc    = 1'b0;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        case (r_state)
            S_INIT: begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_RUN;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_RUN, S_STALL: begin
                // A taken branch squashes the stalled instruction, so it wins over a stall.
                if (bus.branch_taken) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    if (BRANCH_PENALTY == 1) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = CW'(BRANCH_PENALTY - 2);
                    end
                end else if ((r_state == S_STALL) || w_hazard) begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_stall_inc    = 1'b1;
                    if (r_state == S_RUN) begin
                        if (LOAD_STALL == 1) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = CW'(LOAD_STALL - 2);
                        end
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_RUN;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_INIT;
            r_cnt         <= CW'(INIT_CYCLES - 1);
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall_inc && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.stall_count  = r_stall_count;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: default, LOAD_STALL=3 and CNT_W=2 instances.
module tb_id_hazard_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_hazard_if #(.CNT_W(16)) if_main ();
    id_hazard_if #(.CNT_W(16)) if_ls3 ();
    id_hazard_if #(.CNT_W(2))  if_c2 ();

    id_hazard_ctrl #(.CNT_W(16)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_main.slave));
    id_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u_ls3 (.clk(clk), .rst_n(rst_n), .bus(if_ls3.slave));
    id_hazard_ctrl #(.CNT_W(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(if_c2.slave));

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] O_INIT  = 4'b0011;
    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0001;
    localparam logic [3:0] O_FLUSH = 4'b1111;

    typedef struct {
        string       name;
        int          dut;
        logic        rstn;
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  rt;
        logic        br;
        logic [3:0]  outs;
        logic [15:0] cnt;
        logic        ext;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  outs;
        logic [15:0] cnt;
        logic        ext;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sel   = 0;

    logic [3:0]  obs_outs;
    logic [15:0] obs_cnt;
    logic        obs_ext;

    always_comb begin
        case (sel)
            1: begin
                obs_outs = {if_ls3.pc_write, if_ls3.if_id_write, if_ls3.if_id_flush, if_ls3.id_ex_bubble};
                obs_cnt  = if_ls3.stall_count;
                obs_ext  = if_ls3.ext_zero;
            end
            2: begin
                obs_outs = {if_c2.pc_write, if_c2.if_id_write, if_c2.if_id_flush, if_c2.id_ex_bubble};
                obs_cnt  = {14'd0, if_c2.stall_count};
                obs_ext  = if_c2.ext_zero;
            end
            default: begin
                obs_outs = {if_main.pc_write, if_main.if_id_write, if_main.if_id_flush, if_main.id_ex_bubble};
                obs_cnt  = if_main.stall_count;
                obs_ext  = if_main.ext_zero;
            end
        endcase
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic drive(input int d, input logic [31:0] instr, input logic mr,
                         input logic [4:0] rt, input logic br);
        if_main.IF_ID_instr = '0; if_main.id_ex_memread = 1'b0; if_main.id_ex_rt = '0; if_main.branch_taken = 1'b0;
        if_ls3.IF_ID_instr  = '0; if_ls3.id_ex_memread  = 1'b0; if_ls3.id_ex_rt  = '0; if_ls3.branch_taken  = 1'b0;
        if_c2.IF_ID_instr   = '0; if_c2.id_ex_memread   = 1'b0; if_c2.id_ex_rt   = '0; if_c2.branch_taken   = 1'b0;
        case (d)
            1: begin if_ls3.IF_ID_instr = instr; if_ls3.id_ex_memread = mr; if_ls3.id_ex_rt = rt; if_ls3.branch_taken = br; end
            2: begin if_c2.IF_ID_instr  = instr; if_c2.id_ex_memread  = mr; if_c2.id_ex_rt  = rt; if_c2.branch_taken  = br; end
            default: begin if_main.IF_ID_instr = instr; if_main.id_ex_memread = mr; if_main.id_ex_rt = rt; if_main.branch_taken = br; end
        endcase
    endtask

    // Drive one cycle just after the rising edge, record the expectation, sample on the falling edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst_n = v.rstn;
        sel   = v.dut;
        drive(v.dut, v.instr, v.mr, v.rt, v.br);
        sb_q.push_back('{v.name, v.outs, v.cnt, v.ext});
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t v[8];
        exp_t e;
        v = '{
            '{"rst_low0",  0, 1'b0, 32'd0,           1'b0, 5'd0, 1'b0, O_INIT, 16'd0, 1'b0},
            '{"rst_low1",  0, 1'b0, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b1, O_INIT, 16'd0, 1'b0},
            '{"rst_low2",  0, 1'b0, 32'd0,           1'b0, 5'd0, 1'b0, O_INIT, 16'd0, 1'b0},
            '{"init1",     0, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_INIT, 16'd0, 1'b0},
            '{"init2_ign", 0, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_INIT, 16'd0, 1'b0},
            '{"init3_ign", 0, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b1, O_INIT, 16'd0, 1'b0},
            '{"init4",     0, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_INIT, 16'd0, 1'b0},
            '{"run_first", 0, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_RUN,  16'd0, 1'b0}
        };
        foreach (v[i]) begin
            step(v[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t v[8];
        exp_t e;
        v = '{
            '{"lu_add_stall",  0, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_STALL, 16'd0, 1'b0},
            '{"lu_resume",     0, 1'b1, mk(6'h00, 8, 10), 1'b0, 5'd8, 1'b0, O_RUN,   16'd1, 1'b0},
            '{"src_addi_rs",   0, 1'b1, mk(6'h08, 8, 9),  1'b1, 5'd8, 1'b0, O_STALL, 16'd1, 1'b0},
            '{"src_lw_rt_dst", 0, 1'b1, mk(6'h23, 9, 8),  1'b1, 5'd8, 1'b0, O_RUN,   16'd2, 1'b0},
            '{"src_r0",        0, 1'b1, mk(6'h00, 0, 0),  1'b1, 5'd0, 1'b0, O_RUN,   16'd2, 1'b0},
            '{"src_sw_rt",     0, 1'b1, mk(6'h2B, 9, 8),  1'b1, 5'd8, 1'b0, O_STALL, 16'd2, 1'b0},
            '{"src_no_load",   0, 1'b1, mk(6'h00, 9, 8),  1'b0, 5'd8, 1'b0, O_RUN,   16'd3, 1'b0},
            '{"src_addi_rt",   0, 1'b1, mk(6'h08, 9, 8),  1'b1, 5'd8, 1'b0, O_RUN,   16'd3, 1'b0}
        };
        foreach (v[i]) begin
            step(v[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    task automatic test_branch_and_ext();
        vec_t v[8];
        exp_t e;
        v = '{
            '{"br_over_haz",  0, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b1, O_FLUSH, 16'd3, 1'b0},
            '{"br_flush2",    0, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b1, O_FLUSH, 16'd3, 1'b0},
            '{"br_done",      0, 1'b1, mk(6'h00, 9, 10), 1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b0},
            '{"ext_ori",      0, 1'b1, mk(6'h0D, 8, 9),  1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b1},
            '{"ext_andi",     0, 1'b1, mk(6'h0C, 8, 9),  1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b1},
            '{"ext_xori",     0, 1'b1, mk(6'h0E, 8, 9),  1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b1},
            '{"ext_addi",     0, 1'b1, mk(6'h08, 8, 9),  1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b0},
            '{"ext_lui",      0, 1'b1, mk(6'h0F, 0, 9),  1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b0}
        };
        foreach (v[i]) begin
            step(v[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t v[7];
        exp_t e;
        v = '{
            '{"ar_enter_flush", 0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b1, O_FLUSH, 16'd3, 1'b0},
            '{"ar_mid_cycle",   0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, O_INIT,  16'd0, 1'b0},
            '{"ar_init1",       0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, O_INIT,  16'd0, 1'b0},
            '{"ar_init2",       0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, O_INIT,  16'd0, 1'b0},
            '{"ar_init3",       0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, O_INIT,  16'd0, 1'b0},
            '{"ar_init4",       0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, O_INIT,  16'd0, 1'b0},
            '{"ar_run",         0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, O_RUN,   16'd0, 1'b0}
        };
        foreach (v[i]) begin
            if (i == 1) begin
                // Pull reset mid-cycle while sitting in FLUSH; outputs must react without a clock edge.
                #2;
                rst_n = 1'b0;
                sb_q.push_back('{v[i].name, v[i].outs, v[i].cnt, v[i].ext});
                #1;
            end else begin
                step(v[i]);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    task automatic test_load_stall3();
        vec_t v[8];
        exp_t e;
        v = '{
            '{"ls3_hazard",   1, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_STALL, 16'd0, 1'b0},
            '{"ls3_stall2",   1, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_STALL, 16'd1, 1'b0},
            '{"ls3_stall3",   1, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_STALL, 16'd2, 1'b0},
            '{"ls3_resume",   1, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_RUN,   16'd3, 1'b0},
            '{"ls3_hazard_b", 1, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_STALL, 16'd3, 1'b0},
            '{"ls3_branch",   1, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b1, O_FLUSH, 16'd4, 1'b0},
            '{"ls3_flush2",   1, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_FLUSH, 16'd4, 1'b0},
            '{"ls3_run",      1, 1'b1, 32'd0,           1'b0, 5'd0, 1'b0, O_RUN,   16'd4, 1'b0}
        };
        foreach (v[i]) begin
            step(v[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    task automatic test_saturate();
        vec_t v;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                v = '{"sat_hazard", 2, 1'b1, mk(6'h00, 8, 10), 1'b1, 5'd8, 1'b0, O_STALL,
                      16'((i / 2) < 3 ? (i / 2) : 3), 1'b0};
            else
                v = '{"sat_quiet", 2, 1'b1, mk(6'h0D, 8, 9), 1'b0, 5'd0, 1'b0, O_RUN,
                      16'((i / 2 + 1) < 3 ? (i / 2 + 1) : 3), 1'b1};
            step(v);
            e = sb_q.pop_front();
            n_cmp++;
            if ({obs_outs, obs_cnt, obs_ext} !== {e.outs, e.cnt, e.ext}) begin
                n_bad++;
                $display("FAIL %s[%0d]: got outs=%b cnt=%0d ext=%b, want outs=%b cnt=%0d ext=%b",
                         e.name, i, obs_outs, obs_cnt, obs_ext, e.outs, e.cnt, e.ext);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 32'd0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_load_use();
        test_branch_and_ext();
        test_async_reset();
        test_load_stall3();
        test_saturate();
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
